// File: rtl/microsequencer_pkg.sv
// Shared control-unit definitions for the microsequencer and the microstore.
// Holds the sequencing-action and condition-source encodings, the state-number
// geometry, and the bit positions of the sequencing fields in the 38-bit
// control word.
package microsequencer_pkg;

  localparam int unsigned CuStateW     = 10;
  localparam int unsigned CuNumStates  = 50;
  localparam int unsigned CuStackDepth = 4;

  // Control-word layout for the sequencing fields.
  localparam int unsigned CwWidth      = 38;
  localparam int unsigned CwNsSelLsb   = 0;   // 3 bits
  localparam int unsigned CwCondSelLsb = 3;   // 2 bits
  localparam int unsigned CwCondInvBit = 5;   // 1 bit
  localparam int unsigned CwCrAddrLsb  = 6;   // CuStateW bits

  typedef enum logic [2:0] {
    NsFetch  = 3'd0,
    NsInc    = 3'd1,
    NsJump   = 3'd2,
    NsDecode = 3'd3,
    NsBranch = 3'd4,
    NsWait   = 3'd5,
    NsCall   = 3'd6,
    NsReturn = 3'd7
  } ns_sel_e;

  typedef enum logic [1:0] {
    CondMoc  = 2'd0,
    CondTrue = 2'd1,
    CondIrq  = 2'd2,
    CondOne  = 2'd3
  } cond_sel_e;

endpackage

// File: rtl/usq_return_stack.sv
// Micro-subroutine return stack: LIFO of Depth entries, each Width bits.
// Ports:
//   clk, reset      clock, synchronous active-low reset (clears occupancy only)
//   push, pop       requests; push on full and pop on empty are ignored
//   push_data       value pushed
//   top_data        most recently pushed entry (undefined when empty)
//   full, empty     occupancy status
//   depth           number of occupied entries
module usq_return_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic [2:0]       depth
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [2:0]       count_q;
  logic [AddrW-1:0] wr_idx;
  logic [AddrW-1:0] rd_idx;

  assign full     = (count_q == 3'(Depth));
  assign empty    = (count_q == 3'd0);
  assign wr_idx   = AddrW'(count_q);
  assign rd_idx   = AddrW'(count_q - 3'd1);
  assign top_data = mem_q[rd_idx];
  assign depth    = count_q;

  // Entry contents are don't-care after reset, so storage has no reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= 3'd0;
    end else if (push && !full) begin
      count_q <= count_q + 3'd1;
    end else if (pop && !empty) begin
      count_q <= count_q - 3'd1;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Next-state generator for the hardwired-microprogram control unit.
// Owns the registered state number feeding the microstore and selects the
// following state from the control word's sequencing fields, the decoder
// entry state and the condition inputs. Includes a return stack for
// micro-subroutines.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   ns_sel            sequencing action (ns_sel_e)
//   cond_sel,cond_inv condition source (cond_sel_e) and inversion
//   cr_addr           target state from the control word
//   decode_state      entry state from the instruction decoder
//   moc,cond_true,irq condition inputs
//   stall             freezes state, stack and flags
//   next_state        registered current state
//   stack_depth       occupied return-stack entries
//   stack_err         sticky: push on full or pop on empty
//   range_err         sticky: out-of-range target redirected to 0
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int unsigned STATE_W     = CuStateW,
  parameter int unsigned NUM_STATES  = CuNumStates,
  parameter int unsigned STACK_DEPTH = CuStackDepth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_sel,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [STATE_W-1:0] decode_state,
  input  logic               moc,
  input  logic               cond_true,
  input  logic               irq,
  input  logic               stall,
  output logic [STATE_W-1:0] next_state,
  output logic [2:0]         stack_depth,
  output logic               stack_err,
  output logic               range_err
);

  localparam logic [STATE_W-1:0] NumStatesW = STATE_W'(NUM_STATES);

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] state_inc;
  logic [STATE_W-1:0] target;
  logic [STATE_W-1:0] stack_top;
  logic               cond_raw, cond;
  logic               push_req, pop_req;
  logic               stack_full, stack_empty;
  logic               stack_err_set, range_err_set;
  logic               stack_err_q, range_err_q;

  assign state_inc = state_q + STATE_W'(1);

  always_comb begin
    cond_raw = 1'b0;
    unique case (cond_sel_e'(cond_sel))
      CondMoc:  cond_raw = moc;
      CondTrue: cond_raw = cond_true;
      CondIrq:  cond_raw = irq;
      CondOne:  cond_raw = 1'b1;
    endcase
    cond = cond_raw ^ cond_inv;
  end

  always_comb begin
    target        = state_inc;
    push_req      = 1'b0;
    pop_req       = 1'b0;
    stack_err_set = 1'b0;
    unique case (ns_sel_e'(ns_sel))
      NsFetch:  target = '0;
      NsInc:    target = state_inc;
      NsJump:   target = cr_addr;
      NsDecode: target = decode_state;
      NsBranch: target = cond ? cr_addr : state_inc;
      NsWait:   target = cond ? state_inc : state_q;
      NsCall: begin
        // The jump is taken even when the return address cannot be saved.
        target = cr_addr;
        if (stack_full) stack_err_set = 1'b1;
        else            push_req      = 1'b1;
      end
      NsReturn: begin
        if (stack_empty) begin
          target        = '0;
          stack_err_set = 1'b1;
        end else begin
          target  = stack_top;
          pop_req = 1'b1;
        end
      end
    endcase

    // Every computed target, including popped values and S+1, is range checked.
    range_err_set = 1'b0;
    state_d       = target;
    if (target >= NumStatesW) begin
      state_d       = '0;
      range_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= '0;
      stack_err_q <= 1'b0;
      range_err_q <= 1'b0;
    end else if (!stall) begin
      state_q     <= state_d;
      stack_err_q <= stack_err_q | stack_err_set;
      range_err_q <= range_err_q | range_err_set;
    end
  end

  usq_return_stack #(
    .Depth (STACK_DEPTH),
    .Width (STATE_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req & ~stall),
    .pop       (pop_req & ~stall),
    .push_data (state_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .depth     (stack_depth)
  );

  assign next_state = state_q;
  assign stack_err  = stack_err_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;
  import microsequencer_pkg::*;

  typedef struct {
    string      name;
    logic [9:0] s;
    logic [2:0] d;
    logic       se;
    logic       re;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] ns_sel = 3'd0;
  logic [1:0] cond_sel = 2'd0;
  logic       cond_inv = 1'b0;
  logic [9:0] cr_addr = '0;
  logic [9:0] decode_state = '0;
  logic       moc = 1'b0;
  logic       cond_true = 1'b0;
  logic       irq = 1'b0;
  logic       stall = 1'b0;
  logic [9:0] next_state;
  logic [2:0] stack_depth;
  logic       stack_err;
  logic       range_err;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ns_sel       (ns_sel),
    .cond_sel     (cond_sel),
    .cond_inv     (cond_inv),
    .cr_addr      (cr_addr),
    .decode_state (decode_state),
    .moc          (moc),
    .cond_true    (cond_true),
    .irq          (irq),
    .stall        (stall),
    .next_state   (next_state),
    .stack_depth  (stack_depth),
    .stack_err    (stack_err),
    .range_err    (range_err)
  );

  // Queue the expected post-edge state for the next applied step.
  task automatic expect_state(input string name, input int s, input int d,
                              input logic se, input logic re);
    snap_t e;
    e.name = name;
    e.s    = 10'(s);
    e.d    = 3'(d);
    e.se   = se;
    e.re   = re;
    exp_q.push_back(e);
  endtask

  // Drive one control word, clock once, capture outputs #1 after the edge.
  task automatic apply(input ns_sel_e ns, input int cr = 0, input int cs = 0,
                       input logic inv = 1'b0, input logic m = 1'b0,
                       input logic ct = 1'b0, input logic i = 1'b0,
                       input logic st = 1'b0, input logic rst = 1'b1,
                       input int dec = 0);
    snap_t o;
    ns_sel       = ns;
    cr_addr      = 10'(cr);
    cond_sel     = 2'(cs);
    cond_inv     = inv;
    moc          = m;
    cond_true    = ct;
    irq          = i;
    stall        = st;
    reset        = rst;
    decode_state = 10'(dec);
    @(posedge clk);
    #1;
    o.name = "";
    o.s    = next_state;
    o.d    = stack_depth;
    o.se   = stack_err;
    o.re   = range_err;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    snap_t e, o;
    expect_state("reset_under_stall", 0, 0, 0, 0); apply(NsInc, 0, 0, 0, 0, 0, 0, 1, 0);
    expect_state("jump60_flag", 0, 0, 0, 1);       apply(NsJump, 60);
    expect_state("inc_1", 1, 0, 0, 1);             apply(NsInc);
    expect_state("inc_2", 2, 0, 0, 1);             apply(NsInc);
    expect_state("inc_3", 3, 0, 0, 1);             apply(NsInc);
    expect_state("reset_s3_over_call", 0, 0, 0, 0); apply(NsCall, 20, 0, 0, 0, 0, 0, 1, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no output captured, required s=%0d", e.name, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o.s !== e.s || o.d !== e.d || o.se !== e.se || o.re !== e.re) begin
          errors++;
          $display("FAIL %s: got s=%0d d=%0d se=%b re=%b, required s=%0d d=%0d se=%b re=%b",
                   e.name, o.s, o.d, o.se, o.re, e.s, e.d, e.se, e.re);
        end
      end
    end
  endtask

  task automatic test_wait_branch();
    snap_t e, o;
    expect_state("jump5", 5, 0, 0, 0); apply(NsJump, 5);
    for (int k = 0; k < 4; k++) begin
      expect_state("wait_hold", 5, 0, 0, 0); apply(NsWait, 0, 0, 0, 0);
    end
    expect_state("wait_exit", 6, 0, 0, 0);     apply(NsWait, 0, 0, 0, 1);
    expect_state("winv_hold_a", 6, 0, 0, 0);   apply(NsWait, 0, 0, 1, 1);
    expect_state("winv_hold_b", 6, 0, 0, 0);   apply(NsWait, 0, 0, 1, 1);
    expect_state("winv_exit", 7, 0, 0, 0);     apply(NsWait, 0, 0, 1, 0);
    expect_state("br_ctrue", 40, 0, 0, 0);     apply(NsBranch, 40, 1, 0, 0, 1);
    expect_state("br_irq0", 41, 0, 0, 0);      apply(NsBranch, 10, 2, 0, 0, 0, 0);
    expect_state("br_one_inv", 42, 0, 0, 0);   apply(NsBranch, 10, 3, 1);
    expect_state("br_one", 20, 0, 0, 0);       apply(NsBranch, 20, 3, 0);
    expect_state("br_irq1", 33, 0, 0, 0);      apply(NsBranch, 33, 2, 0, 0, 0, 1);
    expect_state("fetch", 0, 0, 0, 0);         apply(NsFetch, 17);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no output captured, required s=%0d", e.name, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o.s !== e.s || o.d !== e.d || o.se !== e.se || o.re !== e.re) begin
          errors++;
          $display("FAIL %s: got s=%0d d=%0d se=%b re=%b, required s=%0d d=%0d se=%b re=%b",
                   e.name, o.s, o.d, o.se, o.re, e.s, e.d, e.se, e.re);
        end
      end
    end
  endtask

  task automatic test_call_return();
    snap_t e, o;
    expect_state("jump12", 12, 0, 0, 0);    apply(NsJump, 12);
    expect_state("call20", 20, 1, 0, 0);    apply(NsCall, 20);
    expect_state("sub_inc", 21, 1, 0, 0);   apply(NsInc);
    expect_state("ret13", 13, 0, 0, 0);     apply(NsReturn);
    expect_state("b2b_call30", 30, 1, 0, 0); apply(NsCall, 30);
    expect_state("b2b_ret14", 14, 0, 0, 0); apply(NsReturn);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no output captured, required s=%0d", e.name, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o.s !== e.s || o.d !== e.d || o.se !== e.se || o.re !== e.re) begin
          errors++;
          $display("FAIL %s: got s=%0d d=%0d se=%b re=%b, required s=%0d d=%0d se=%b re=%b",
                   e.name, o.s, o.d, o.se, o.re, e.s, e.d, e.se, e.re);
        end
      end
    end
  endtask

  task automatic test_nested();
    snap_t e, o;
    // Starts at S = 14 with an empty stack.
    for (int k = 1; k <= 4; k++) begin
      expect_state($sformatf("call_nest%0d", k), k, k, 0, 0); apply(NsCall, k);
    end
    expect_state("call_full", 5, 4, 1, 0);  apply(NsCall, 5);
    expect_state("ret_a", 4, 3, 1, 0);      apply(NsReturn);
    expect_state("ret_b", 3, 2, 1, 0);      apply(NsReturn);
    expect_state("ret_c", 2, 1, 1, 0);      apply(NsReturn);
    expect_state("ret_d", 15, 0, 1, 0);     apply(NsReturn);
    expect_state("ret_empty", 0, 0, 1, 0);  apply(NsReturn);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no output captured, required s=%0d", e.name, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o.s !== e.s || o.d !== e.d || o.se !== e.se || o.re !== e.re) begin
          errors++;
          $display("FAIL %s: got s=%0d d=%0d se=%b re=%b, required s=%0d d=%0d se=%b re=%b",
                   e.name, o.s, o.d, o.se, o.re, e.s, e.d, e.se, e.re);
        end
      end
    end
  endtask

  task automatic test_range();
    snap_t e, o;
    expect_state("rng_reset_a", 0, 0, 0, 0);  apply(NsInc, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("jump49", 49, 0, 0, 0);      apply(NsJump, 49);
    expect_state("call_from49", 10, 1, 0, 0); apply(NsCall, 10);
    expect_state("ret_pop50", 0, 0, 0, 1);    apply(NsReturn);
    expect_state("rng_reset_b", 0, 0, 0, 0);  apply(NsInc, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("jump50_edge", 0, 0, 0, 1);  apply(NsJump, 50);
    expect_state("rng_reset_c", 0, 0, 0, 0);  apply(NsInc, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("jump60", 0, 0, 0, 1);       apply(NsJump, 60);
    expect_state("decode49", 49, 0, 0, 1);    apply(NsDecode, 0, 0, 0, 0, 0, 0, 0, 1, 49);
    expect_state("inc_past_end", 0, 0, 0, 1); apply(NsInc);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no output captured, required s=%0d", e.name, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o.s !== e.s || o.d !== e.d || o.se !== e.se || o.re !== e.re) begin
          errors++;
          $display("FAIL %s: got s=%0d d=%0d se=%b re=%b, required s=%0d d=%0d se=%b re=%b",
                   e.name, o.s, o.d, o.se, o.re, e.s, e.d, e.se, e.re);
        end
      end
    end
  endtask

  task automatic test_stall();
    snap_t e, o;
    expect_state("stl_reset", 0, 0, 0, 0);     apply(NsInc, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_state("jump7", 7, 0, 0, 0);         apply(NsJump, 7);
    expect_state("stall_call_a", 7, 0, 0, 0);  apply(NsCall, 30, 0, 0, 0, 0, 0, 1);
    expect_state("stall_call_b", 7, 0, 0, 0);  apply(NsCall, 30, 0, 0, 0, 0, 0, 1);
    expect_state("stall_ret", 7, 0, 0, 0);     apply(NsReturn, 0, 0, 0, 0, 0, 0, 1);
    expect_state("stall_jump60", 7, 0, 0, 0);  apply(NsJump, 60, 0, 0, 0, 0, 0, 1);
    expect_state("call30_go", 30, 1, 0, 0);    apply(NsCall, 30);
    expect_state("stall_in_sub", 30, 1, 0, 0); apply(NsReturn, 0, 0, 0, 0, 0, 0, 1);
    expect_state("ret8", 8, 0, 0, 0);          apply(NsReturn);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no output captured, required s=%0d", e.name, e.s);
      end else begin
        o = obs_q.pop_front();
        if (o.s !== e.s || o.d !== e.d || o.se !== e.se || o.re !== e.re) begin
          errors++;
          $display("FAIL %s: got s=%0d d=%0d se=%b re=%b, required s=%0d d=%0d se=%b re=%b",
                   e.name, o.s, o.d, o.se, o.re, e.s, e.d, e.se, e.re);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wait_branch();
    test_call_return();
    test_nested();
    test_range();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
